// File: rtl/mdu_pkg.sv
// mdu_pkg
// Shared definitions for the multiply/divide sequencing controller:
//   - 4-bit MDU op encodings seen in the D and E pipeline stages
//   - controller FSM state type
//   - small op-classification helpers used by the controller
package mdu_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MFHI  = 4'd5;
  localparam logic [3:0] MDU_MFLO  = 4'd6;
  localparam logic [3:0] MDU_MTHI  = 4'd7;
  localparam logic [3:0] MDU_MTLO  = 4'd8;
  localparam logic [3:0] MDU_BDS   = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_COMMIT = 2'd2
  } mdu_state_e;

  // Ops that occupy the unit for a multi-cycle latency.
  function automatic logic is_long_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) ||
           (op == MDU_DIVU) || (op == MDU_BDS);
  endfunction

  // Multiplies use the shorter latency; every other long op uses the divide latency.
  function automatic logic is_mult_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  // HI/LO writes, which must not race an in-flight operation.
  function automatic logic is_mt_op(input logic [3:0] op);
    return (op == MDU_MTHI) || (op == MDU_MTLO);
  endfunction

  // HI/LO reads, which are always passed through.
  function automatic logic is_mf_op(input logic [3:0] op);
    return (op == MDU_MFHI) || (op == MDU_MFLO);
  endfunction

  // Any real MDU instruction (codes 10-15 behave as none).
  function automatic logic is_mdu_op(input logic [3:0] op);
    return (op >= MDU_MULT) && (op <= MDU_BDS);
  endfunction

endpackage

// File: rtl/mdu_lat_counter.sv
// mdu_lat_counter
// Loadable down-counter that times an in-flight MDU operation.
// Ports:
//   clk        - rising-edge clock
//   reset      - synchronous active-low reset, clears the count
//   load_i     - load load_val_i this cycle (takes priority over dec_i)
//   load_val_i - value to load (latency minus one)
//   dec_i      - decrement by one; saturates at zero
//   last_o     - count equals one, i.e. the final execute cycle
module mdu_lat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         last_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: a load restarts timing, otherwise count down without wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == W'(1));

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl
// Sequencing controller for the multiply/divide unit. Accepts long ops from
// E, times their latency, pulses the HI/LO commit and requests D-stage stalls
// while an MDU instruction would collide with an in-flight operation.
// Ports:
//   clk, reset        - clock and synchronous active-low reset
//   e_valid, e_op     - E-stage instruction valid and MDU op
//   d_valid, d_op     - D-stage instruction valid and MDU op
//   mdu_op            - op presented to the MDU datapath
//   mdu_start         - combinational: long op accepted this cycle
//   mdu_busy          - registered: an operation is in flight
//   hilo_we           - registered one-cycle HI/LO commit pulse
//   stall_d           - combinational stall request to the hazard unit
//   err               - sticky flag: an MDU op reached E while busy
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       e_valid,
  input  logic [3:0] e_op,
  input  logic       d_valid,
  input  logic [3:0] d_op,
  output logic [3:0] mdu_op,
  output logic       mdu_start,
  output logic       mdu_busy,
  output logic       hilo_we,
  output logic       stall_d,
  output logic       err
);

  localparam int MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (MAX_LAT <= 2) ? 1 : $clog2(MAX_LAT);

  mdu_state_e       state_q;
  logic             busy_q;
  logic             hiloWe_q;
  logic             err_q;
  logic             isIdle;
  logic             startOp;
  logic             illegalOp;
  logic             cntLast;
  logic             cntDec;
  logic [CNT_W-1:0] loadVal;

  assign isIdle  = (state_q == ST_IDLE);
  assign startOp = reset && isIdle && e_valid && is_long_op(e_op);

  // An op that needs the unit arriving while busy means a stall was ignored.
  assign illegalOp = !isIdle && e_valid && (is_long_op(e_op) || is_mt_op(e_op));

  assign loadVal = is_mult_op(e_op) ? CNT_W'(MULT_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);
  assign cntDec  = (state_q == ST_RUN) && !cntLast;

  mdu_lat_counter #(
    .W(CNT_W)
  ) u_lat_counter (
    .clk       (clk),
    .reset     (reset),
    .load_i    (startOp),
    .load_val_i(loadVal),
    .dec_i     (cntDec),
    .last_o    (cntLast)
  );

  // Controller FSM with registered busy, commit pulse and sticky error flag.
  // The commit pulse is raised on entry to COMMIT so it is high exactly there.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      hiloWe_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      hiloWe_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (startOp) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (cntLast) begin
            state_q  <= ST_COMMIT;
            hiloWe_q <= 1'b1;
          end
        end
        ST_COMMIT: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
      if (illegalOp) begin
        err_q <= 1'b1;
      end
    end
  end

  // Datapath op: reads always pass, long ops and writes only when the unit is free.
  always_comb begin
    mdu_op = MDU_NONE;
    if (reset && e_valid) begin
      if (is_mf_op(e_op)) begin
        mdu_op = e_op;
      end else if (isIdle && (is_long_op(e_op) || is_mt_op(e_op))) begin
        mdu_op = e_op;
      end
    end
  end

  assign mdu_start = startOp;
  assign mdu_busy  = busy_q;
  assign hilo_we   = hiloWe_q;
  assign err       = err_q;
  assign stall_d   = reset && d_valid && is_mdu_op(d_op) && (busy_q || startOp);

endmodule
